l1_pmem_arbiter: RTL and testbench
==================================

// Module: l1_pmem_arbiter
// PURPOSE
// Arbitrates the L1I and L1D miss/writeback ports onto the single L2/physical-memory line port.
// Sits directly downstream of both L1 caches, and one L1 line transaction is in flight at a time.
// Grants are round-robin on conflict, and the request is registered at grant so L2 sees stable
// address/data. A saturating conflict counter is exported for the performance-counter block.
// PARAMETERS
// ADDR_W   32    byte address width, all address ports
// LINE_W   256   cache line width, all data ports
// CNT_W    32    conflict counter width
// PORTS
// clk              in   1       system clock, all state on rising edge
// rst              in   1       asynchronous, active-high reset
// i_pmem_address   in   ADDR_W  L1I line address
// i_pmem_read      in   1       L1I line read request, held until i_pmem_resp
// i_pmem_rdata     out  LINE_W  line data to L1I, valid with i_pmem_resp
// i_pmem_resp      out  1       L1I transaction done, 1-cycle pulse
// d_pmem_address   in   ADDR_W  L1D line address
// d_pmem_wdata     in   LINE_W  L1D writeback line
// d_pmem_read      in   1       L1D line read request, held until d_pmem_resp
// d_pmem_write     in   1       L1D line write request, held until d_pmem_resp
// d_pmem_rdata     out  LINE_W  line data to L1D, valid with d_pmem_resp
// d_pmem_resp      out  1       L1D transaction done, 1-cycle pulse
// l2_address       out  ADDR_W  registered line address to L2
// l2_wdata         out  LINE_W  registered write line to L2
// l2_read          out  1       L2 read strobe, held until l2_resp
// l2_write         out  1       L2 write strobe, held until l2_resp
// l2_rdata         in   LINE_W  L2 read data, valid with l2_resp
// l2_resp          in   1       L2 transaction done
// conflict_clear   in   1       synchronous clear of conflict_count
// conflict_count   out  CNT_W   cycles in IDLE with both L1I and L1D requesting
// BEHAVIOUR
// - FSM states: IDLE, SERVE_I, SERVE_D. Reset state is IDLE.
// - Reset values: all outputs 0, last_grant=I, conflict_count=0. Reset is async: it aborts any
//   in-flight L2 transaction, and l2_read/l2_write drop the moment rst is asserted.
// - In IDLE: req_i=i_pmem_read; req_d=d_pmem_read|d_pmem_write.
//   - Only one request -> grant it.
//   - Both requests -> grant the client that is not last_grant. D wins the first conflict after reset.
//   - On grant edge: latch address; for D also latch wdata and op; update last_grant; go SERVE_x.
// - Op: D with d_pmem_write=1 -> write, taking precedence if read is also high. Otherwise read.
//   I is always read.
// - SERVE_x: l2_read/l2_write driven from the latched op, held until l2_resp.
//   - Arbitration latency is 1 cycle: request seen in cycle N, L2 strobe asserted in N+1.
//   - Client address/wdata changes during SERVE are ignored.
// - Completion: in the cycle l2_resp=1, x_pmem_resp=1 combinationally (only the granted client).
//   - l2_read/l2_write are still high in that cycle.
//   - Next edge -> IDLE, strobes low.
//   - Requests are re-sampled in that IDLE cycle. Clients deassert the cycle after resp, so there
//     is no replay.
// - i_pmem_rdata = d_pmem_rdata = l2_rdata (broadcast). Only meaningful when qualified by resp.
// - l2_resp in IDLE is ignored. No resp is ever generated to a client that is not granted.
// - conflict_count:
//   - +1 on each IDLE cycle with req_i & req_d.
//   - Saturates at all-ones, no wrap.
//   - When conflict_clear and an increment occur in the same cycle, the clear wins (result 0).
// - Back-to-back transactions to the same client are allowed, with 1 IDLE cycle between them.
// TESTING
// 1. I read 0x0000_0040, L2 resp after 3 cycles, rdata=0xDEAD..BEEF -> l2_read cycle N+1,
//    l2_address=0x40, i_pmem_resp pulses once with that data, d_pmem_resp stays 0.
// 2. After reset, I read 0x100 and D read 0x200 in the same cycle -> D served first
//    (l2_address=0x200), then I (0x100); conflict_count=1.
// 3. Four consecutive conflicts with both clients re-requesting -> grants D,I,D,I;
//    conflict_count=4.
// 4. D write 0x80, wdata=0xA5 repeated; client changes wdata to 0 after grant -> l2_write=1,
//    l2_wdata stays 0xA5.., d_pmem_resp on l2_resp.
// 5. rst pulsed mid SERVE_D -> l2_read/l2_write go 0 asynchronously; a later l2_resp produces no
//    client resp; conflict_count=0.
// 6. conflict_clear in the same cycle as a conflict -> count reads 0 next cycle. Forced count at
//    all-ones plus a conflict -> count stays all-ones.

Source files
------------

// File: rtl/l1_pmem_arbiter.sv
// rtl/l1_pmem_arbiter.sv - round-robin arbiter of L1I/L1D line ports onto one L2 line port
// One transaction in flight; the request is registered at grant so L2 sees stable address/data.
module l1_pmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic              i_pmem_read,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    output logic              l2_read,
    output logic              l2_write,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp,
    input  logic              conflict_clear,
    output logic [CNT_W-1:0]  conflict_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state, next_state;
    logic   last_grant_d;
    logic   op_write;
    logic   req_i, req_d, conflict;

    assign req_i    = i_pmem_read;
    assign req_d    = d_pmem_read | d_pmem_write;
    assign conflict = (state == IDLE) && req_i && req_d;

    // On conflict the client that did not win last time goes first; last_grant resets to I so D wins first.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_d && (!req_i || !last_grant_d))
                    next_state = SERVE_D;
                else if (req_i)
                    next_state = SERVE_I;
            end
            SERVE_I, SERVE_D: begin
                if (l2_resp)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
            op_write     <= 1'b0;
            l2_address   <= '0;
            l2_wdata     <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == SERVE_D) begin
                l2_address   <= d_pmem_address;
                l2_wdata     <= d_pmem_wdata;
                op_write     <= d_pmem_write;
                last_grant_d <= 1'b1;
            end else if (state == IDLE && next_state == SERVE_I) begin
                l2_address   <= i_pmem_address;
                op_write     <= 1'b0;
                last_grant_d <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            conflict_count <= '0;
        else if (conflict_clear)
            conflict_count <= '0;
        else if (conflict && !(&conflict_count))
            conflict_count <= conflict_count + CNT_ONE;
    end

    // Strobes decode straight from state so an async reset drops them immediately.
    assign l2_read      = (state == SERVE_I) || ((state == SERVE_D) && !op_write);
    assign l2_write     = (state == SERVE_D) && op_write;
    assign i_pmem_resp  = (state == SERVE_I) && l2_resp;
    assign d_pmem_resp  = (state == SERVE_D) && l2_resp;
    assign i_pmem_rdata = l2_rdata;
    assign d_pmem_rdata = l2_rdata;

endmodule

// File: tb/tb_l1_pmem_arbiter.sv
// tb/tb_l1_pmem_arbiter.sv - directed self-checking bench for l1_pmem_arbiter
module tb_l1_pmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] i_pmem_address;
    logic              i_pmem_read;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic [ADDR_W-1:0] d_pmem_address;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic              l2_read;
    logic              l2_write;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;
    logic              conflict_clear;
    logic [CNT_W-1:0]  conflict_count;

    int total = 0;
    int bad   = 0;

    logic [LINE_W-1:0] beef_line;
    logic [LINE_W-1:0] a5_line;

    l1_pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_address (i_pmem_address),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .l2_address     (l2_address),
        .l2_wdata       (l2_wdata),
        .l2_read        (l2_read),
        .l2_write       (l2_write),
        .l2_rdata       (l2_rdata),
        .l2_resp        (l2_resp),
        .conflict_clear (conflict_clear),
        .conflict_count (conflict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        beef_line      = {8{32'hDEAD_BEEF}};
        a5_line        = {32{8'hA5}};
        rst            = 1'b0;
        i_pmem_address = '0;
        i_pmem_read    = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        l2_rdata       = '0;
        l2_resp        = 1'b0;
        conflict_clear = 1'b0;
        do_reset();

        check("rst_l2_read", l2_read, 0);
        check("rst_l2_write", l2_write, 0);
        check("rst_l2_address", l2_address, 0);
        check("rst_count", conflict_count, 0);

        // 1: I read 0x40, L2 answers in the third serve cycle
        i_pmem_address = 32'h40;
        i_pmem_read    = 1'b1;
        check("t1_idle_no_strobe", l2_read, 0);
        step();
        check("t1_l2_read", l2_read, 1);
        check("t1_l2_address", l2_address, 32'h40);
        check("t1_no_early_resp", i_pmem_resp, 0);
        step();
        step();
        check("t1_held_read", l2_read, 1);
        l2_rdata = beef_line;
        l2_resp  = 1'b1;
        #1;
        check("t1_i_resp", i_pmem_resp, 1);
        check("t1_i_rdata", i_pmem_rdata, beef_line);
        check("t1_d_resp_quiet", d_pmem_resp, 0);
        check("t1_read_at_resp", l2_read, 1);
        step();
        l2_resp     = 1'b0;
        i_pmem_read = 1'b0;
        #1;
        check("t1_idle_read_low", l2_read, 0);
        check("t1_i_resp_pulse", i_pmem_resp, 0);
        step();
        check("t1_no_replay", l2_read, 0);

        // 2: simultaneous I/D after reset, D first
        do_reset();
        i_pmem_address = 32'h100;
        i_pmem_read    = 1'b1;
        d_pmem_address = 32'h200;
        d_pmem_read    = 1'b1;
        step();
        check("t2_first_addr", l2_address, 32'h200);
        check("t2_first_read", l2_read, 1);
        check("t2_count", conflict_count, 1);
        l2_resp = 1'b1;
        #1;
        check("t2_d_resp", d_pmem_resp, 1);
        check("t2_i_not_resp", i_pmem_resp, 0);
        step();
        l2_resp     = 1'b0;
        d_pmem_read = 1'b0;
        step();
        check("t2_second_addr", l2_address, 32'h100);
        check("t2_second_read", l2_read, 1);
        check("t2_count_hold", conflict_count, 1);
        l2_resp = 1'b1;
        #1;
        check("t2_i_resp", i_pmem_resp, 1);
        check("t2_d_not_resp", d_pmem_resp, 0);
        step();
        l2_resp     = 1'b0;
        i_pmem_read = 1'b0;

        // 3: four back-to-back conflicts alternate D,I,D,I
        do_reset();
        i_pmem_read = 1'b1;
        d_pmem_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("t3_grant%0d", k), l2_address, (k % 2 == 0) ? 32'h200 : 32'h100);
            check($sformatf("t3_count%0d", k), conflict_count, k + 1);
            l2_resp = 1'b1;
            #1;
            check($sformatf("t3_resp%0d", k), {i_pmem_resp, d_pmem_resp}, (k % 2 == 0) ? 2'b01 : 2'b10);
            step();
            l2_resp = 1'b0;
        end
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        check("t3_count_final", conflict_count, 4);
        step();
        check("t3_count_stable", conflict_count, 4);

        // 4: D write with read also high; wdata changes after grant
        d_pmem_address = 32'h80;
        d_pmem_wdata   = a5_line;
        d_pmem_write   = 1'b1;
        d_pmem_read    = 1'b1;
        step();
        d_pmem_wdata   = '0;
        d_pmem_address = 32'h1234;
        step();
        check("t4_l2_write", l2_write, 1);
        check("t4_l2_read_low", l2_read, 0);
        check("t4_l2_wdata", l2_wdata, a5_line);
        check("t4_l2_address", l2_address, 32'h80);
        l2_resp = 1'b1;
        #1;
        check("t4_d_resp", d_pmem_resp, 1);
        step();
        l2_resp      = 1'b0;
        d_pmem_write = 1'b0;
        d_pmem_read  = 1'b0;
        #1;
        check("t4_write_drop", l2_write, 0);

        // 5: async reset mid SERVE_D (count is 4 from test 3)
        d_pmem_address = 32'h200;
        d_pmem_read    = 1'b1;
        step();
        check("t5_serving", l2_read, 1);
        d_pmem_read = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_read", l2_read, 0);
        check("t5_async_write", l2_write, 0);
        check("t5_async_count", conflict_count, 0);
        step();
        rst     = 1'b0;
        l2_resp = 1'b1;
        #1;
        check("t5_no_d_resp", d_pmem_resp, 0);
        check("t5_no_i_resp", i_pmem_resp, 0);
        step();
        check("t5_idle_after", l2_read, 0);
        l2_resp = 1'b0;

        // 6: clear beats increment, then saturation at all-ones
        i_pmem_read    = 1'b1;
        d_pmem_read    = 1'b1;
        conflict_clear = 1'b1;
        step();
        conflict_clear = 1'b0;
        check("t6_clear_wins", conflict_count, 0);
        l2_resp = 1'b1;
        step();
        l2_resp = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            l2_resp = 1'b1;
            step();
            l2_resp = 1'b0;
        end
        check("t6_saturate", conflict_count, 4'hF);
        step();
        l2_resp = 1'b1;
        step();
        l2_resp = 1'b0;
        check("t6_saturate_hold", conflict_count, 4'hF);
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
